line_score_accum: RTL and testbench
===================================

# line_score_accum

Score and level bookkeeping stage for the Tetris playfield. It accepts one line-clear event at a time from the board logic and converts it into a number of points. It then advances the 12-bit score and the 12-bit line total one step per cycle through a +1 incrementer datapath. Its outputs go straight to the score/level display and to the gravity-speed logic.

## Interface
- WIDTH, 12: score and line-total width; fixed at 12 to match the incrementer datapath.
- LEVEL_W, 4: level width; level saturates at 2^LEVEL_W-1 = 15.
- LINES_PER_LEVEL, 10: lines cleared per level step.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- game_reset  in  1  synchronous clear of score, lines, level and FSM
- clear_valid  in  1  line-clear event offered
- clear_lines  in  3  lines cleared by the event (0..7, see Operation)
- clear_ready  out  1  high only in IDLE and when game_reset is low
- busy  out  1  high in AWARD or LINES
- score  out  WIDTH  current score
- lines_total  out  WIDTH  total lines cleared
- level  out  LEVEL_W  current level
- score_sat  out  1  sticky flag: score has reached 4095

## Operation
- Reset values: score=0, lines_total=0, level=0, score_sat=0, busy=0, clear_ready=1, FSM=IDLE, internal lines_mod counter=0.
- The rst values above also apply on game_reset, one edge later. game_reset works from any state and abandons any pending work.
- Accept: clear_valid && clear_ready at a rising edge.
- Base points (package constants):
  - Line count to base points: 1→1, 2→3, 3→5, 4→8.
  - clear_lines 5..7 is clamped to 4.
- clear_lines=0: the handshake completes, nothing changes, and the FSM stays in IDLE.
- Pending award P = base × (level+1), using the level value at acceptance. P has a maximum of 128 and is held in an 8-bit down-counter. N is the clamped line count, held in a 3-bit down-counter.
- FSM states:
  - IDLE: on accept with N≥1, load P and N and go to AWARD.
  - AWARD: each cycle, score ← score+1 through the incrementer, or holds at 4095, and P decrements. When P=1, go to LINES.
  - LINES: each cycle, lines_total ← lines_total+1 (holds at 4095) and lines_mod increments. When lines_mod wraps 9→0, level increments, saturating at 15. N decrements; when N=1, go to IDLE.
- Saturation:
  - Once score reaches 4095, score_sat=1 until rst or game_reset.
  - Remaining P is still consumed cycle by cycle, so latency is independent of saturation.
- A level change during LINES affects only the next event's P.
- clear_valid while not ready is ignored. No queueing; upstream must hold the event until it is accepted.

## Timing
- Accept at edge T. AWARD occupies edges T+1..T+P and LINES occupies edges T+P+1..T+P+N.
- clear_ready is high again after edge T+P+N, so the next accept can occur at T+P+N+1.
- score is visible, registered, one cycle after each AWARD edge. There is no output combinational path from inputs except clear_ready←game_reset.
- Simultaneous game_reset and clear_valid: clear_ready is low, the event is not accepted, and the clear takes priority.
- rst asserted mid-operation: all state returns to reset values immediately. After deassertion the block is in IDLE.

## Structure
- Package tetris_score_pkg:
  - SCORE_W=12, LEVEL_W=4, LEVEL_MAX=15, LINES_PER_LEVEL=10
  - base-points constants PTS_1..PTS_4
  - state enum {IDLE, AWARD, LINES}
- Sub-module score_inc12: a combinational 12-bit +1 with carry-out. It is instantiated twice, for score and lines_total. Its carry-out drives the saturation hold.
- Remaining logic: the FSM, the P/N down-counters, lines_mod (0..9) and the level register, in one module.

## Test plan
- rst pulse mid-AWARD: all outputs are 0 and clear_ready=1 immediately. Outputs stay there until the first accept.
- Level 0, clear_lines=4 accepted at T:
  - score steps 1..8 over T+1..T+8
  - lines_total=4 at T+12
  - clear_ready=1 after T+12
- Events 4, 4, 2 from reset: level becomes 1 on the 10th LINES edge. Then clear_lines=1 gives P=2, so score goes from 19 to 21.
- Score driven to 4090, then clear_lines=4 at level 0: score=4095, score_sat=1 and stays set, and total busy time is still 12 cycles.
- Edge cases:
  - game_reset during AWARD: next cycle all outputs are 0 and state is IDLE.
  - clear_valid in the same cycle as game_reset: not accepted.
  - clear_valid while busy: ignored.
- clear_lines=0: handshake completes, no state change, ready stays 1. clear_lines=6 behaves as 4 (P=8 at level 0).

Source files
------------

// File: rtl/tetris_score_pkg.sv
// Shared constants, FSM state type and line-count helpers for the score/level stage.
// No ports; imported by line_score_accum.
// Base points are small enough (max 8) that a 4-bit field holds them.
package tetris_score_pkg;

  localparam int SCORE_W         = 12;
  localparam int LEVEL_W         = 4;
  localparam int LEVEL_MAX       = 15;
  localparam int LINES_PER_LEVEL = 10;

  localparam logic [3:0] PTS_1 = 4'd1;
  localparam logic [3:0] PTS_2 = 4'd3;
  localparam logic [3:0] PTS_3 = 4'd5;
  localparam logic [3:0] PTS_4 = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AWARD = 2'd1,
    LINES = 2'd2
  } state_t;

  // Events reporting more than four lines are treated as a four-line clear.
  function automatic logic [2:0] clamp_lines(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  function automatic logic [3:0] base_points(input logic [2:0] n);
    case (n)
      3'd1:    return PTS_1;
      3'd2:    return PTS_2;
      3'd3:    return PTS_3;
      3'd4:    return PTS_4;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/score_inc12.sv
// Combinational 12-bit +1 incrementer with carry-out; zero latency, no handshake.
// Ports: i_a operand, o_sum = i_a+1 (mod 4096), o_carry set when i_a is 4095.
// The carry-out is what the owner uses to hold a counter at full scale.
module score_inc12 (
  input  logic [11:0] i_a,
  output logic [11:0] o_sum,
  output logic        o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + 13'd1;

endmodule

// File: rtl/line_score_accum.sv
// Converts one line-clear event into points, then steps score and line total by one per cycle.
// Latency: accept at T, score steps over T+1..T+P, lines over T+P+1..T+P+N, ready after T+P+N.
// Backpressure: i_clear_ready only in IDLE with game_reset low; no queueing, upstream holds the event.
// Ports: i_clk/i_rst (async, active-high), i_game_reset (sync clear), i_clear_valid/i_clear_lines/o_clear_ready
// handshake, o_busy, o_score, o_lines_total, o_level, o_score_sat (sticky full-scale score).
module line_score_accum #(
  parameter int WIDTH           = tetris_score_pkg::SCORE_W,
  parameter int LEVEL_W         = tetris_score_pkg::LEVEL_W,
  parameter int LINES_PER_LEVEL = tetris_score_pkg::LINES_PER_LEVEL
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_game_reset,
  input  logic               i_clear_valid,
  input  logic [2:0]         i_clear_lines,
  output logic               o_clear_ready,
  output logic               o_busy,
  output logic [WIDTH-1:0]   o_score,
  output logic [WIDTH-1:0]   o_lines_total,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_score_sat
);

  import tetris_score_pkg::*;

  localparam int                 LM_W    = $clog2(LINES_PER_LEVEL);
  localparam logic [LM_W-1:0]    LM_LAST = LM_W'(LINES_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP = '1;

  state_t             r_state;
  logic [7:0]         r_p;
  logic [2:0]         r_n;
  logic [WIDTH-1:0]   r_score;
  logic [WIDTH-1:0]   r_lines;
  logic [LM_W-1:0]    r_lines_mod;
  logic [LEVEL_W-1:0] r_level;
  logic               r_score_sat;

  logic               w_accept;
  logic [2:0]         w_n_clamped;
  logic [3:0]         w_base;
  logic [LEVEL_W:0]   w_lvl_p1;
  logic [7:0]         w_p_load;
  logic [WIDTH-1:0]   w_score_sum;
  logic               w_score_co;
  logic [WIDTH-1:0]   w_lines_sum;
  logic               w_lines_co;

  // game_reset must block acceptance in the same cycle, hence the combinational term.
  assign o_clear_ready = (r_state == IDLE) && !i_game_reset;
  assign o_busy        = (r_state != IDLE);
  assign o_score       = r_score;
  assign o_lines_total = r_lines;
  assign o_level       = r_level;
  assign o_score_sat   = r_score_sat;

  assign w_accept    = i_clear_valid && o_clear_ready;
  assign w_n_clamped = clamp_lines(i_clear_lines);
  assign w_base      = base_points(w_n_clamped);
  assign w_lvl_p1    = {1'b0, r_level} + 1'b1;
  // Largest award is 8 x 16 = 128, so an 8-bit product never overflows.
  assign w_p_load    = 8'(w_base) * 8'(w_lvl_p1);

  score_inc12 u_score_inc (
    .i_a     (r_score),
    .o_sum   (w_score_sum),
    .o_carry (w_score_co)
  );

  score_inc12 u_lines_inc (
    .i_a     (r_lines),
    .o_sum   (w_lines_sum),
    .o_carry (w_lines_co)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_n         <= '0;
      r_score     <= '0;
      r_lines     <= '0;
      r_lines_mod <= '0;
      r_level     <= '0;
      r_score_sat <= 1'b0;
    end else if (i_game_reset) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_n         <= '0;
      r_score     <= '0;
      r_lines     <= '0;
      r_lines_mod <= '0;
      r_level     <= '0;
      r_score_sat <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A zero-line event completes the handshake without leaving IDLE.
          if (w_accept && (w_n_clamped != 3'd0)) begin
            r_p     <= w_p_load;
            r_n     <= w_n_clamped;
            r_state <= AWARD;
          end
        end
        AWARD: begin
          // Carry-out means score is already 4095: hold, but keep draining P so
          // latency does not depend on saturation.
          if (!w_score_co) begin
            r_score <= w_score_sum;
            if (&w_score_sum) r_score_sat <= 1'b1;
          end
          r_p <= r_p - 8'd1;
          if (r_p == 8'd1) r_state <= LINES;
        end
        LINES: begin
          if (!w_lines_co) r_lines <= w_lines_sum;
          if (r_lines_mod == LM_LAST) begin
            r_lines_mod <= '0;
            if (r_level != LVL_TOP) r_level <= r_level + 1'b1;
          end else begin
            r_lines_mod <= r_lines_mod + 1'b1;
          end
          r_n <= r_n - 3'd1;
          if (r_n == 3'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_score_accum.sv
module tb_line_score_accum;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_game_reset = 1'b0;
  logic        i_clear_valid = 1'b0;
  logic [2:0]  i_clear_lines = 3'd0;
  logic        o_clear_ready;
  logic        o_busy;
  logic [11:0] o_score;
  logic [11:0] o_lines_total;
  logic [3:0]  o_level;
  logic        o_score_sat;

  line_score_accum dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_game_reset  (i_game_reset),
    .i_clear_valid (i_clear_valid),
    .i_clear_lines (i_clear_lines),
    .o_clear_ready (o_clear_ready),
    .o_busy        (o_busy),
    .o_score       (o_score),
    .o_lines_total (o_lines_total),
    .o_level       (o_level),
    .o_score_sat   (o_score_sat)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int score;
    int lines;
    int level;
    int sat;
    int cyc;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_score = 0;
  int m_lines = 0;
  int m_level = 0;
  int m_lmod  = 0;
  int m_sat   = 0;

  task automatic chk(input string tag, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  function automatic int pts(input int n);
    case (n)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_score = 0; m_lines = 0; m_level = 0; m_lmod = 0; m_sat = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_score"}, o_score, 0);
    chk({tag, "_lines"}, o_lines_total, 0);
    chk({tag, "_level"}, o_level, 0);
    chk({tag, "_sat"},   o_score_sat, 0);
    chk({tag, "_busy"},  o_busy, 0);
  endtask

  // Offer one event while idle, follow it to completion, compare against scoreboard.
  task automatic do_event(input logic [2:0] n, input bit spam);
    int   nc;
    int   p;
    int   s0;
    int   cnt;
    exp_t e;
    nc = (n > 3'd4) ? 4 : int'(n);
    p  = pts(nc) * (m_level + 1);
    s0 = m_score;
    m_score = imin(m_score + p, 4095);
    if (m_score == 4095) m_sat = 1;
    for (int i = 0; i < nc; i++) begin
      m_lines = imin(m_lines + 1, 4095);
      m_lmod++;
      if (m_lmod == 10) begin
        m_lmod = 0;
        if (m_level < 15) m_level++;
      end
    end
    e.score = m_score; e.lines = m_lines; e.level = m_level;
    e.sat = m_sat; e.cyc = p + nc;
    sb.push_back(e);

    chk("ready_before", o_clear_ready, 1);
    i_clear_valid = 1'b1;
    i_clear_lines = n;
    @(posedge i_clk); #1;
    i_clear_valid = 1'b0;
    i_clear_lines = 3'd0;
    cnt = 0;
    while (o_busy && cnt < 400) begin
      // offers made while busy must be ignored
      if (spam && cnt >= 1 && cnt <= 3) begin
        i_clear_valid = 1'b1;
        i_clear_lines = 3'd4;
      end else begin
        i_clear_valid = 1'b0;
        i_clear_lines = 3'd0;
      end
      @(posedge i_clk); #1;
      cnt++;
      if (cnt <= p) chk("score_step", o_score, imin(s0 + cnt, 4095));
    end
    i_clear_valid = 1'b0;

    e = sb.pop_front();
    chk("busy_cycles", cnt, e.cyc);
    chk("score",       o_score, e.score);
    chk("lines_total", o_lines_total, e.lines);
    chk("level",       o_level, e.level);
    chk("score_sat",   o_score_sat, e.sat);
    chk("ready_after", o_clear_ready, 1);
  endtask

  initial begin
    // power-on reset
    #2 i_rst = 1'b1;
    #1 chk_zero("rst");
    chk("rst_ready", o_clear_ready, 1);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk_zero("post_rst");

    // level 0: 4 lines -> 8 points, 12 busy cycles
    do_event(3'd4, 1'b0);
    // second 4-line event with offers during busy that must be dropped
    do_event(3'd4, 1'b1);
    // 2 lines crosses 10 lines -> level 1 (score 19)
    do_event(3'd2, 1'b0);
    chk("lvl_after_10", o_level, 1);
    // single line at level 1 -> P=2 (score 21)
    do_event(3'd1, 1'b0);
    chk("score_21", o_score, 21);
    // zero-line event: handshake only
    do_event(3'd0, 1'b0);

    // game_reset mid-AWARD, with a simultaneous offer
    i_clear_valid = 1'b1; i_clear_lines = 3'd4;
    @(posedge i_clk); #1;
    i_clear_valid = 1'b0; i_clear_lines = 3'd0;
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("gr_busy_pre", o_busy, 1);
    i_game_reset = 1'b1; i_clear_valid = 1'b1; i_clear_lines = 3'd4;
    @(posedge i_clk); #1;
    // one idle cycle with game_reset still high: ready must stay low
    chk("gr_ready_low", o_clear_ready, 0);
    @(posedge i_clk); #1;
    chk_zero("gr");
    i_game_reset = 1'b0; i_clear_valid = 1'b0; i_clear_lines = 3'd0;
    #1 chk("gr_ready_back", o_clear_ready, 1);
    @(posedge i_clk); #1;
    chk_zero("gr_after");
    model_clear();

    // 6 lines clamps to 4 -> P=8 at level 0
    do_event(3'd6, 1'b0);
    chk("clamp6_score", o_score, 8);

    // async rst in the middle of AWARD
    i_clear_valid = 1'b1; i_clear_lines = 3'd3;
    @(posedge i_clk); #1;
    i_clear_valid = 1'b0; i_clear_lines = 3'd0;
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1 chk_zero("arst");
    chk("arst_ready", o_clear_ready, 1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    chk_zero("arst_after");
    chk("arst_after_ready", o_clear_ready, 1);
    model_clear();

    // drive score to full scale; busy time must not shrink once saturated
    while (m_score < 3800) do_event(3'd4, 1'b0);
    chk("sat_not_yet", o_score_sat, 0);
    while (m_sat == 0) do_event(3'd4, 1'b0);
    do_event(3'd4, 1'b0);
    chk("sat_score", o_score, 4095);
    chk("sat_flag", o_score_sat, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
